pmu_counter_bank: RTL
=====================

Name: pmu_counter_bank

Overview:
Bank of N free-running event counters. It sits directly upstream of the per-core quota checker and drives that checker's counter-value array. Each counter increments once per cycle while its registered event input is high and the bank is enabled. Software can preload any counter through a single write port. Each counter has a sticky wrap-around (overflow) flag, and the masked OR of these flags drives an overflow interrupt.

Parameters:
- REG_WIDTH, 32: width of each counter.
- N_COUNTERS, 9: number of counters.
- IDX_W, $clog2(N_COUNTERS) (localparam): width of the write index.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- softrst_i, in, 1: soft reset from config registers; synchronous, active-high.
- en_i, in, 1: global count enable.
- events_i, in, N_COUNTERS: per-counter event strobes, one bit per counter.
- we_i, in, 1: counter write strobe.
- wr_idx_i, in, IDX_W: index of the counter to write.
- wr_data_i, in, REG_WIDTH: value to write.
- ovf_clr_i, in, N_COUNTERS: per-counter overflow-flag clear, one-cycle pulse.
- ovf_mask_i, in, N_COUNTERS: overflow interrupt mask; 1 = enabled.
- counter_value_o, out, REG_WIDTH x [0:N_COUNTERS-1]: counter values, driven directly from flops.
- ovf_o, out, N_COUNTERS: sticky overflow flags.
- intr_ovf_o, out, 1: |(ovf_o & ovf_mask_i), registered.

Behaviour:
- Reset and soft reset
  - rst_i or softrst_i at a clock edge clears: all counters, ovf_o, intr_ovf_o, the event pipeline register and en_q.
  - All outputs read 0 after that edge.
  - rst_i and softrst_i have identical effect and take priority over everything else.
- Event pipeline
  - events_i is registered into ev_q; en_i is registered into en_q in the same stage.
- Counting
  - At each edge, counter k increments by 1 when ev_q[k] & en_q.
  - Latency: an event high before edge t appears in counter_value_o after edge t+1 (2-cycle latency).
  - An event pulse of L cycles yields exactly L increments.
- Write
  - When we_i is high and wr_idx_i < N_COUNTERS, the selected counter loads wr_data_i at that edge.
  - Write beats increment in the same cycle: that cycle's increment is lost.
  - wr_idx_i >= N_COUNTERS: the write is ignored; no state changes.
  - Writing a counter does not change its ovf flag.
- Wrap-around
  - An increment from all-ones gives 0 and sets ovf_o[k] at the same edge.
  - If the same counter is written in that cycle, the write wins and ovf is not set.
- Flag clear
  - ovf_clr_i[k] clears ovf_o[k].
  - If a wrap occurs in the same cycle, set beats clear and the flag stays 1.
- Interrupt
  - intr_ovf_o is registered: it reflects ovf_o & ovf_mask_i one edge after ovf_o changes.
  - A mask change takes effect at the next edge.
- en_i low: counters hold; writes and flag clears still act.
- Reset mid-count: an event already held in ev_q is discarded; there is no increment on the edge after reset deasserts.
- Arithmetic: unsigned modulo 2^REG_WIDTH; no saturation.

Decomposition:
- Shared package pmu_pkg holds: default REG_WIDTH and N_COUNTERS, the IDX_W derivation function, and a typedef for the counter-array element (logic [REG_WIDTH-1:0]).
- One sub-module, pmu_counter_cell: a single counter plus its ovf flag, with inputs inc, load, load_data, clr and rst.
  - It contains the write/increment/clear priority logic.
  - The bank generates N instances, plus the event pipeline and interrupt register.

Test Plan:
1. Reset
   - Stimulus: assert rst_i for 2 cycles with events_i=all ones and en_i=1.
   - Required: all counter_value_o=0, ovf_o=0, intr_ovf_o=0. After release, counter0 reads 1 two edges later.
2. Count, latency, enable gating
   - Stimulus: en_i=1; pulse events_i[3] for 5 cycles.
   - Required: counter3 reads 5, starting one edge after the pulse's first edge. Repeat with en_i=0: counter3 stays 5.
3. Write priority and bad index
   - Stimulus: write 0x100 to idx 2 while ev_q[2]=1.
   - Required: counter2=0x100, not 0x101.
   - Stimulus: write to idx 9 (N_COUNTERS=9).
   - Required: no counter changes.
4. Wrap and interrupt
   - Stimulus: write 0xFFFFFFFE to idx 0; count 2 events; ovf_mask_i[0]=1.
   - Required: counter0=0, ovf_o[0]=1, intr_ovf_o=1 one edge later. With ovf_mask_i[0]=0, intr_ovf_o stays 0.
5. Clear versus set collision
   - Stimulus: counter1=0xFFFFFFFF; ovf_clr_i[1] pulsed on the same edge as the wrapping increment.
   - Required: ovf_o[1]=1. A later clear alone gives ovf_o[1]=0, and intr_ovf_o=0 the edge after.
6. Soft reset mid-operation
   - Stimulus: counters at non-zero values with events streaming; pulse softrst_i for 1 cycle.
   - Required: all counters and flags read 0. Counting resumes with no spurious increment from the flushed ev_q.

Source files
------------

// File: rtl/pmu_pkg.sv
// Shared defaults, width helper and counter element type for the PMU counter bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmu_pkg;

  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_N_COUNTERS = 9;

  // Index width for a bank of n counters; a single-counter bank still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One element of the counter-value array handed to the quota checker.
  typedef logic [DEF_REG_WIDTH-1:0] pmu_cnt_t;

endpackage

// File: rtl/pmu_counter_cell.sv
// One event counter with its sticky wrap-around flag; software load beats increment, wrap beats clear.
// Latency: inc/load/clr land in value_o/ovf_o at the next clock edge.
// Backpressure: none; every request is absorbed in the cycle it is presented.
module pmu_counter_cell
  import pmu_pkg::*;
#(
  parameter int unsigned REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 load_i,
  input  logic [REG_WIDTH-1:0] load_data_i,
  input  logic                 clr_i,
  output logic [REG_WIDTH-1:0] value_o,
  output logic                 ovf_o
);

  logic [REG_WIDTH-1:0] value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 wrap;

  // Next-state priority: a load discards the increment (and any wrap it would cause);
  // a wrap sets the flag even when a clear arrives on the same edge.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    wrap    = inc_i && !load_i && (value_q == '1);
    if (load_i) begin
      value_d = load_data_i;
    end else if (inc_i) begin
      value_d = value_q + REG_WIDTH'(1);
    end
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // Counter and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pmu_counter_bank.sv
// Bank of free-running event counters with preload port, sticky wrap flags and masked overflow interrupt.
// Latency: event to counter_value_o 2 edges; write/clear 1 edge; ovf_o to intr_ovf_o 1 edge.
// Backpressure: none; events, writes and clears are accepted every cycle.
module pmu_counter_bank
  import pmu_pkg::*;
#(
  parameter  int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter  int unsigned N_COUNTERS = DEF_N_COUNTERS,
  localparam int unsigned IDX_W      = idx_width(N_COUNTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  softrst_i,
  input  logic                  en_i,
  input  logic [N_COUNTERS-1:0] events_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [REG_WIDTH-1:0]  wr_data_i,
  input  logic [N_COUNTERS-1:0] ovf_clr_i,
  input  logic [N_COUNTERS-1:0] ovf_mask_i,
  output logic [REG_WIDTH-1:0]  counter_value_o [0:N_COUNTERS-1],
  output logic [N_COUNTERS-1:0] ovf_o,
  output logic                  intr_ovf_o
);

  // Hard and soft reset are indistinguishable inside the bank.
  logic rst_all;
  assign rst_all = rst_i | softrst_i;

  logic [N_COUNTERS-1:0] ev_q, ev_d;
  logic                  en_q, en_d;
  logic                  intr_q, intr_d;
  logic [N_COUNTERS-1:0] ovf_w;

  // Event/enable pipeline inputs and interrupt reduction over the registered flags.
  always_comb begin
    ev_d   = events_i;
    en_d   = en_i;
    intr_d = |(ovf_w & ovf_mask_i);
  end

  // Event pipeline stage and interrupt register; reset flushes any event already captured.
  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      ev_q   <= '0;
      en_q   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ev_q   <= ev_d;
      en_q   <= en_d;
      intr_q <= intr_d;
    end
  end

  // Indices at or above N_COUNTERS decode to no cell, so such writes fall away.
  for (genvar k = 0; k < N_COUNTERS; k++) begin : g_cell
    logic cell_inc;
    logic cell_load;
    assign cell_inc  = ev_q[k] & en_q;
    assign cell_load = we_i && (wr_idx_i == IDX_W'(k));

    pmu_counter_cell #(
      .REG_WIDTH(REG_WIDTH)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_all),
      .inc_i      (cell_inc),
      .load_i     (cell_load),
      .load_data_i(wr_data_i),
      .clr_i      (ovf_clr_i[k]),
      .value_o    (counter_value_o[k]),
      .ovf_o      (ovf_w[k])
    );
  end

  assign ovf_o      = ovf_w;
  assign intr_ovf_o = intr_q;

endmodule
